i2c_tdm_target: RTL



---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 54 +++++
 rtl/i2c_tdm_target.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings (also decoded from state_out), ACK levels, general-call address.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_ADDR       = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK   = 4'd2;
    localparam logic [3:0] ST_PTR        = 4'd3;
    localparam logic [3:0] ST_PTR_ACK    = 4'd4;
    localparam logic [3:0] ST_WDATA      = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK  = 4'd6;
    localparam logic [3:0] ST_RDATA      = 4'd7;
    localparam logic [3:0] ST_RDATA_MACK = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP  = 4'd9;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] GENCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and derives one-cycle SCL edge and START/STOP condition pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_cur;
    logic                   sda_cur;

    assign scl_cur = scl_sync_q[SYNC_STAGES-1];
    assign sda_cur = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_cur;
        sda_prev_d = sda_cur;
    end

    // Reset to the released (high) bus level so reset exit never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_s    = sda_cur;
    assign scl_rise = scl_cur & ~scl_prev_q;
    assign scl_fall = ~scl_cur & scl_prev_q;
    assign start    = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
    assign stop     = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

endmodule

// File: rtl/i2c_tdm_target.sv
// I2C target with a byte register file and auto-incrementing pointer; dev_enable emulates device power.
// Optional macro I2C_TGT_GENCALL_EN: ACK and discard general-call (0x00, W) transfers.
module i2c_tdm_target
    import i2c_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int PTR_W       = $clog2(NUM_REGS),
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dev_enable,
    input  logic [6:0]       tgt_addr,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic             loc_we,
    input  logic [PTR_W-1:0] loc_addr,
    input  logic [7:0]       loc_wdata,
    output logic [7:0]       loc_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             addressed,
    output logic             busy,
    output logic [3:0]       state_out
);

`ifdef I2C_TGT_GENCALL_EN
    localparam logic GENCALL_EN = 1'b1;
`else
    localparam logic GENCALL_EN = 1'b0;
`endif

    logic             sda_s, scl_rise, scl_fall, start, stop;
    logic [3:0]       state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             addressed_q, addressed_d;
    logic             gencall_q, gencall_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic [7:0]       rx_byte;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte = {shift_q[6:0], sda_s};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        addressed_d = addressed_q;
        gencall_d   = gencall_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        if (loc_we) regs_d[loc_addr] = loc_wdata;

        if (!dev_enable) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            gencall_d   = 1'b0;
        end else if (start) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            gencall_d   = 1'b0;
        end else if (stop) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            gencall_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (GENCALL_EN && rx_byte[7:1] == GENCALL_ADDR) begin
                            state_d     = rx_byte[0] ? ST_WAIT_STOP : ST_ADDR_ACK;
                            addressed_d = ~rx_byte[0];
                            gencall_d   = ~rx_byte[0];
                        end else if (rx_byte[7:1] == tgt_addr) begin
                            state_d     = ST_ADDR_ACK;
                            addressed_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                // First SCL fall in an ACK state starts driving, the 9th-bit fall releases.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_PTR_ACK;
                        if (!gencall_q) ptr_d = rx_byte[PTR_W-1:0];
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_WDATA_ACK;
                        if (!gencall_q) begin
                            regs_d[ptr_q] = rx_byte;
                            wr_strobe_d   = 1'b1;
                            wr_addr_d     = ptr_q;
                            wr_data_d     = rx_byte;
                            ptr_d         = ptr_q + 1'b1;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_MACK;
                            ptr_d    = ptr_q + 1'b1;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // bit_cnt = 9 marks a controller ACK awaiting the next SCL fall to drive.
                ST_RDATA_MACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) bit_cnt_d = 4'd9;
                        else                  state_d   = ST_WAIT_STOP;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = '0;
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            gencall_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            // NOTE: the register file is reset on purpose; it must read back 0x00 after reset.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            addressed_q <= addressed_d;
            gencall_q   <= gencall_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    // Gating with rst_n releases SDA in the very cycle reset is asserted.
    assign sda_oe    = sda_oe_q & rst_n;
    assign loc_rdata = regs_q[loc_addr];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign addressed = addressed_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule
